// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer for one convolution pass of the PE core
// (weight load, activation load, execute, drain, kernel-offset accumulate).
module core_ctrl #(
  parameter int row      = 8,
  parameter int col      = 8,
  parameter int in_w     = 6,
  parameter int k_sz     = 3,
  parameter int x_base   = 0,
  parameter int w_base   = 64,
  parameter int out_base = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done
);

  localparam int LEN_NIJ  = in_w * in_w;
  localparam int LEN_KIJ  = k_sz * k_sz;
  localparam int OW       = in_w - k_sz + 1;
  localparam int LEN_ONIJ = OW * OW;

  localparam logic [10:0] COL_N  = 11'(col);
  localparam logic [10:0] NIJ_N  = 11'(LEN_NIJ);
  localparam logic [10:0] KIJ_N  = 11'(LEN_KIJ);
  localparam logic [10:0] ONIJ_N = 11'(LEN_ONIJ);
  localparam logic [10:0] OW_N   = 11'(OW);
  localparam logic [10:0] KSZ_N  = 11'(k_sz);
  localparam logic [10:0] INW_N  = 11'(in_w);
  localparam logic [10:0] XB_N   = 11'(x_base);
  localparam logic [10:0] WB_N   = 11'(w_base);
  localparam logic [10:0] OB_N   = 11'(out_base);

  localparam logic [33:0] IDLE_WORD = 34'h1_800C_0000;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_W_L0   = 4'd1;
  localparam logic [3:0] S_W_LOAD = 4'd2;
  localparam logic [3:0] S_W_GAP  = 4'd3;
  localparam logic [3:0] S_X_L0   = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_DRAIN  = 4'd6;
  localparam logic [3:0] S_ACC    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  if (row < 1 || col < 1 || k_sz > in_w) begin : g_geometry_check
    $error("core_ctrl: invalid PE array or kernel geometry");
  end

  logic [3:0]  state, n_state;
  logic [10:0] cnt, n_cnt, kij, n_kij, m, n_m;
  logic [10:0] orow, n_orow, ocol, n_ocol, krow, n_krow, kcol, n_kcol;
  logic [10:0] kidx, n_kidx, olin, n_olin;
  logic [33:0] n_inst;
  logic        n_busy, n_done, drain_wr;

  // Next state/counters first, then the word for that next cycle, so every
  // output leaves a register in step with the state it describes.
  always_comb begin
    n_state  = state;
    n_cnt    = cnt;
    n_kij    = kij;
    n_m      = m;
    n_orow   = orow;
    n_ocol   = ocol;
    n_krow   = krow;
    n_kcol   = kcol;
    n_kidx   = kidx;
    n_olin   = olin;
    n_busy   = busy;
    n_done   = 1'b0;
    n_inst   = IDLE_WORD;
    drain_wr = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          n_state = S_W_L0;
          n_cnt   = '0;
          n_kij   = '0;
          n_busy  = 1'b1;
        end
      end
      S_W_L0: begin
        if (cnt == COL_N) begin
          n_state = S_W_LOAD;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + 11'd1;
        end
      end
      S_W_LOAD: begin
        if (cnt == COL_N - 11'd1) begin
          n_state = S_W_GAP;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + 11'd1;
        end
      end
      S_W_GAP: begin
        if (cnt == COL_N - 11'd1) begin
          n_state = S_X_L0;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + 11'd1;
        end
      end
      S_X_L0: begin
        if (cnt == NIJ_N) begin
          n_state = S_EXEC;
          n_cnt   = '0;
        end else begin
          n_cnt = cnt + 11'd1;
        end
      end
      S_EXEC: begin
        if (cnt == NIJ_N - 11'd1) begin
          n_state = S_DRAIN;
          n_m     = '0;
        end else begin
          n_cnt = cnt + 11'd1;
        end
      end
      S_DRAIN: begin
        if (m == NIJ_N) begin
          if (kij == KIJ_N - 11'd1) begin
            n_state = S_ACC;
            n_orow  = '0;
            n_ocol  = '0;
            n_krow  = '0;
            n_kcol  = '0;
            n_kidx  = '0;
            n_olin  = '0;
          end else begin
            n_state = S_W_L0;
            n_kij   = kij + 11'd1;
            n_cnt   = '0;
          end
        end
      end
      S_ACC: begin
        if (kidx == KIJ_N) begin
          if (olin == ONIJ_N - 11'd1) begin
            n_state = S_DONE;
            n_done  = 1'b1;
            n_busy  = 1'b0;
          end else begin
            n_olin = olin + 11'd1;
            n_kidx = '0;
            n_krow = '0;
            n_kcol = '0;
            if (ocol == OW_N - 11'd1) begin
              n_ocol = '0;
              n_orow = orow + 11'd1;
            end else begin
              n_ocol = ocol + 11'd1;
            end
          end
        end else begin
          n_kidx = kidx + 11'd1;
          if (kcol == KSZ_N - 11'd1) begin
            n_kcol = '0;
            n_krow = krow + 11'd1;
          end else begin
            n_kcol = kcol + 11'd1;
          end
        end
      end
      S_DONE: begin
        n_state = S_IDLE;
      end
      default: begin
        n_state = S_IDLE;
        n_busy  = 1'b0;
      end
    endcase

    // A drain slot only writes when the OFIFO row was present at this edge.
    drain_wr = (n_state == S_DRAIN) && ofifo_valid;

    case (n_state)
      S_W_L0: begin
        if (n_cnt != COL_N) begin
          n_inst[19]   = 1'b0;
          n_inst[17:7] = WB_N + n_kij * COL_N + n_cnt;
        end
        if (n_cnt != 11'd0) n_inst[2] = 1'b1;
      end
      S_W_LOAD: begin
        n_inst[3] = 1'b1;
        n_inst[0] = 1'b1;
      end
      S_X_L0: begin
        if (n_cnt != NIJ_N) begin
          n_inst[19]   = 1'b0;
          n_inst[17:7] = XB_N + n_cnt;
        end
        if (n_cnt != 11'd0) n_inst[2] = 1'b1;
      end
      S_EXEC: begin
        n_inst[3] = 1'b1;
        n_inst[1] = 1'b1;
      end
      S_DRAIN: begin
        if (drain_wr) begin
          n_inst[32]    = 1'b0;
          n_inst[31]    = 1'b0;
          n_inst[30:20] = n_kij * NIJ_N + n_m;
          n_inst[6]     = 1'b1;
          n_m           = n_m + 11'd1;
        end
      end
      S_ACC: begin
        n_inst[32] = 1'b0;
        if (n_kidx != KIJ_N) begin
          n_inst[33]    = 1'b1;
          n_inst[30:20] = n_kidx * NIJ_N + (n_orow + n_krow) * INW_N + n_ocol + n_kcol;
        end else begin
          n_inst[31]    = 1'b0;
          n_inst[30:20] = OB_N + n_olin;
        end
      end
      default: begin
        n_inst = IDLE_WORD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      kij   <= '0;
      m     <= '0;
      orow  <= '0;
      ocol  <= '0;
      krow  <= '0;
      kcol  <= '0;
      kidx  <= '0;
      olin  <= '0;
      inst  <= IDLE_WORD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= n_state;
      cnt   <= n_cnt;
      kij   <= n_kij;
      m     <= n_m;
      orow  <= n_orow;
      ocol  <= n_ocol;
      krow  <= n_krow;
      kcol  <= n_kcol;
      kidx  <= n_kidx;
      olin  <= n_olin;
      inst  <= n_inst;
      busy  <= n_busy;
      done  <= n_done;
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: drives whole convolution passes into two core_ctrl instances
// and compares every output cycle against a phase-level model of the pass.
module tb_core_ctrl;

  localparam logic [33:0] IDLE     = 34'h1_800C_0000;
  localparam logic [33:0] OFIFO_RD = 34'h40;
  localparam logic [33:0] L0_RD    = 34'h8;
  localparam logic [33:0] L0_WR    = 34'h4;
  localparam logic [33:0] EXE      = 34'h2;
  localparam logic [33:0] LOAD     = 34'h1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_big = 1'b0;
  logic        start_small = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [33:0] inst_big, inst_small;
  logic        busy_big, busy_small, done_big, done_small;

  core_ctrl dut_big (
    .clk         (clk),
    .reset       (reset),
    .start       (start_big),
    .ofifo_valid (ofifo_valid),
    .inst        (inst_big),
    .busy        (busy_big),
    .done        (done_big)
  );

  core_ctrl #(.in_w(4), .k_sz(2), .col(4)) dut_small (
    .clk         (clk),
    .reset       (reset),
    .start       (start_small),
    .ofifo_valid (ofifo_valid),
    .inst        (inst_small),
    .busy        (busy_small),
    .done        (done_small)
  );

  always #5 clk = ~clk;

  logic [35:0] exp_q[$];
  logic [35:0] trace [0:2047];
  logic [35:0] act_word;
  int          trace_idx = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          model_e = 0;
  int          done_seen = 0;
  bit          check_en = 1'b0;
  bit          sel = 1'b0;

  task automatic checkOutput(input string name, input logic [35:0] actual, input logic [35:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_bad++;
      $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
    end
  endtask

  // ofifo_valid pattern, indexed by edge number counted from the start edge
  function automatic bit pat(input int mode, input int e);
    case (mode)
      0:       return 1'b1;
      1:       return (e % 2) == 0;
      default: return ((e % 5) != 3) && ((e % 7) != 0);
    endcase
  endfunction

  function automatic logic [33:0] xrd(input int a);
    logic [33:0] w;
    w = IDLE;
    w[19] = 1'b0;
    w[17:7] = a[10:0];
    return w;
  endfunction

  function automatic logic [33:0] prd(input int a);
    logic [33:0] w;
    w = IDLE;
    w[33] = 1'b1;
    w[32] = 1'b0;
    w[30:20] = a[10:0];
    return w;
  endfunction

  function automatic logic [33:0] pwr(input int a);
    logic [33:0] w;
    w = IDLE;
    w[32] = 1'b0;
    w[31] = 1'b0;
    w[30:20] = a[10:0];
    return w;
  endfunction

  task automatic push(input logic [33:0] w, input logic b, input logic d);
    exp_q.push_back({w, b, d});
    model_e++;
  endtask

  // One pass as phase loops: weights, activations, execute, drain per kernel
  // offset, then the shifted-window accumulation and the done pulse.
  task automatic build_pass(input int iw, input int ks, input int c, input int mode);
    int nij, kk, ow, on, m;
    nij = iw * iw;
    kk = ks * ks;
    ow = iw - ks + 1;
    on = ow * ow;
    model_e = 0;
    for (int kij = 0; kij < kk; kij++) begin
      for (int t = 0; t <= c; t++)
        push((t < c ? xrd(64 + kij * c + t) : IDLE) | (t > 0 ? L0_WR : 34'd0), 1'b1, 1'b0);
      for (int t = 0; t < c; t++) push(IDLE | L0_RD | LOAD, 1'b1, 1'b0);
      for (int t = 0; t < c; t++) push(IDLE, 1'b1, 1'b0);
      for (int n = 0; n <= nij; n++)
        push((n < nij ? xrd(n) : IDLE) | (n > 0 ? L0_WR : 34'd0), 1'b1, 1'b0);
      for (int n = 0; n < nij; n++) push(IDLE | L0_RD | EXE, 1'b1, 1'b0);
      m = 0;
      while (m < nij) begin
        if (pat(mode, model_e)) begin
          push(pwr(kij * nij + m) | OFIFO_RD, 1'b1, 1'b0);
          m++;
        end else begin
          push(IDLE, 1'b1, 1'b0);
        end
      end
    end
    for (int o = 0; o < on; o++) begin
      for (int k = 0; k < kk; k++)
        push(prd(k * nij + (o / ow + k / ks) * iw + (o % ow) + (k % ks)), 1'b1, 1'b0);
      push(pwr(1024 + o), 1'b1, 1'b0);
    end
    push(IDLE, 1'b0, 1'b1);
    push(IDLE, 1'b0, 1'b0);
  endtask

  // Drives one queued pass; extra start pulses and reset land on given edges.
  task automatic applyStimulus(input bit which, input int mode, input int reset_at,
                               input int xs1, input int xs2);
    int len;
    len = exp_q.size();
    trace_idx = 0;
    sel = which;
    for (int e = 0; e < len; e++) begin
      @(negedge clk);
      check_en = 1'b1;
      reset = (e == reset_at);
      start_big = !which && (e == 0 || e == xs1 || e == xs2 || e == reset_at);
      start_small = which && (e == 0 || e == xs1 || e == xs2 || e == reset_at);
      ofifo_valid = pat(mode, e);
    end
    @(negedge clk);
    check_en = 1'b0;
    reset = 1'b0;
    start_big = 1'b0;
    start_small = 1'b0;
  endtask

  always @(posedge clk) begin
    #2;
    if (check_en) begin
      act_word = sel ? {inst_small, busy_small, done_small} : {inst_big, busy_big, done_big};
      if (act_word[0]) done_seen++;
      if (trace_idx < 2048) trace[trace_idx] = act_word;
      if (exp_q.size() > 0) begin
        checkOutput($sformatf("cycle%0d", trace_idx), act_word, exp_q.pop_front());
      end else begin
        n_cmp++;
        n_bad++;
        $display("[TB] FAIL model_underrun: actual %h, required none", act_word);
      end
      trace_idx++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: actual timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_big", {inst_big, busy_big, done_big}, {IDLE, 2'b00});
    checkOutput("reset_small", {inst_small, busy_small, done_small}, {IDLE, 2'b00});
    reset = 1'b0;

    build_pass(6, 3, 8, 0);
    checkOutput("model_len_default", 36'(exp_q.size()), 36'd1368);
    applyStimulus(1'b0, 0, -1, 300, -1);
    checkOutput("first_wload_addr64", trace[0], {34'h1_8004_2000, 2'b10});
    checkOutput("acc_o5_k4_addr158", trace[1260], {34'h2_89EC_0000, 2'b10});
    checkOutput("acc_o5_write_1029", trace[1265], {34'h0_405C_0000, 2'b10});
    checkOutput("done_pulse", trace[1366], {IDLE, 2'b01});
    checkOutput("idle_after_done", trace[1367], {IDLE, 2'b00});

    build_pass(6, 3, 8, 1);
    applyStimulus(1'b0, 1, -1, 200, 1300);
    checkOutput("drain_valid_m0", trace[98], {34'h0_000C_0040, 2'b10});
    checkOutput("drain_invalid_hold", trace[99], {IDLE, 2'b10});
    checkOutput("drain_valid_m1", trace[100], {34'h0_001C_0040, 2'b10});

    build_pass(6, 3, 8, 0);
    while (exp_q.size() > 470) void'(exp_q.pop_back());
    push(IDLE, 1'b0, 1'b0);
    push(IDLE, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 470, -1, -1);
    checkOutput("exec_kij3_word", trace[469], {34'h1_800C_000A, 2'b10});
    checkOutput("reset_mid_exec", trace[470], {IDLE, 2'b00});

    build_pass(6, 3, 8, 2);
    applyStimulus(1'b0, 2, -1, -1, -1);
    checkOutput("restart_addr64", trace[0], {34'h1_8004_2000, 2'b10});

    build_pass(4, 2, 4, 0);
    checkOutput("model_len_small", 36'(exp_q.size()), 36'd295);
    applyStimulus(1'b1, 0, -1, -1, -1);
    checkOutput("small_wl0_last", trace[4], {34'h1_800C_0004, 2'b10});
    checkOutput("small_wload_first", trace[5], {34'h1_800C_0009, 2'b10});
    checkOutput("small_last_drain", trace[247], {34'h0_03FC_0040, 2'b10});
    checkOutput("small_acc_first", trace[248], {34'h2_800C_0000, 2'b10});
    checkOutput("small_acc_last_wr", trace[292], {34'h0_408C_0000, 2'b10});
    checkOutput("small_done", trace[293], {IDLE, 2'b01});

    checkOutput("done_pulse_count", 36'(done_seen), 36'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 The block SHALL have parameters (name, default, meaning):
- row, 8: PE array rows.
- col, 8: PE array columns.
- in_w, 6: input feature-map width; len_nij = in_w*in_w.
- k_sz, 3: kernel width; len_kij = k_sz*k_sz; ow = in_w-k_sz+1; len_onij = ow*ow.
- x_base, 0: xmem base address of activations.
- w_base, 64: xmem base address of weights, len_kij blocks of col rows.
- out_base, 1024: pmem base address of accumulated outputs.
REQ-002 The block SHALL have ports (name, direction, width, meaning):
- clk, in, 1: the only clock.
- reset, in, 1: synchronous, active-high reset.
- start, in, 1: begin one full convolution pass.
- ofifo_valid, in, 1: core OFIFO holds a complete row.
- inst, out, 34: core instruction word.
- busy, out, 1: pass in progress.
- done, out, 1: one-cycle pass-complete pulse.
REQ-003 inst fields SHALL be: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load; CEN/WEN are active-low.

Function
REQ-004 inst, busy and done SHALL be driven directly from registers; the idle word is 34'h1_800C_0000 (CEN/WEN high, all else 0).
REQ-005 The FSM SHALL have states IDLE, W_L0, W_LOAD, W_GAP, X_L0, EXEC, DRAIN, ACC, DONE.
REQ-006 IDLE: start=1 SHALL move to W_L0 with kij=0 and raise busy on the same edge; start while busy SHALL be ignored.
REQ-007 W_L0 SHALL issue col xmem reads (CEN=0, WEN=1) at w_base+kij*col+t, t=0..col-1, with l0_wr asserted the cycle after each read; duration col+1 cycles.
REQ-008 W_LOAD SHALL assert l0_rd=1 and load=1 for col cycles.
REQ-009 W_GAP SHALL emit the idle word for col cycles.
REQ-010 X_L0 SHALL read xmem x_base+n, n=0..len_nij-1, with l0_wr one cycle after each read; duration len_nij+1 cycles.
REQ-011 EXEC SHALL assert l0_rd=1 and execute=1 for len_nij cycles.
REQ-012 DRAIN SHALL, in each cycle where ofifo_valid=1, assert ofifo_rd=1 with a pmem write (CEN=0, WEN=0) at A_pmem=kij*len_nij+m, m incrementing; with ofifo_valid=0 it SHALL emit the idle word and hold m. After len_nij writes: kij<len_kij-1 increments kij and goes to W_L0; otherwise it goes to ACC.
REQ-013 ACC SHALL, for o=0..len_onij-1:
- Issue len_kij pmem reads with acc=1 at k*len_nij+nij, where nij=(o/ow+k/k_sz)*in_w+(o%ow+k%k_sz).
- Then issue one pmem write (acc=0) at out_base+o.
- Duration is len_onij*(len_kij+1) cycles.
REQ-014 DONE SHALL last one cycle with done=1, busy=0 and the idle word, then return to IDLE.
REQ-015 All address arithmetic SHALL be 11-bit unsigned; the o/ow and k/k_sz terms SHALL be computed from row/column counters, not by division.
REQ-016 Exactly one of xmem access, pmem access or idle SHALL be active in any inst word.

Reset
REQ-017 reset=1 SHALL, on the next clk edge, force IDLE, inst=idle word, busy=0, done=0 and clear all counters, including mid-pass; no partial pass resumes.
REQ-018 start asserted together with reset SHALL be ignored.

Verification
REQ-019 Defaults, ofifo_valid tied high, single start pulse -> phase lengths per kij: W_L0 9, W_LOAD 8, W_GAP 8, X_L0 37, EXEC 36, DRAIN 36; ACC 160; one done pulse; busy low afterwards.
REQ-020 In ACC, o=5 and k=4 -> A_pmem=158 with acc=1; the write for o=5 goes to A_pmem=1029.
REQ-021 Toggle ofifo_valid 1/0 in DRAIN -> ofifo_rd and the pmem write occur only in valid cycles; A_pmem has no gaps (0..35 for kij=0).
REQ-022 reset=1 during EXEC of kij=3 -> next edge gives inst=34'h1_800C_0000 and busy=0; a new start restarts at kij=0, W_L0 reading address 64.
REQ-023 start pulsed again during busy -> no effect; exactly one done pulse.
REQ-024 Parameters in_w=4, k_sz=2, col=4 -> len_nij=16, ACC lasts 9*5=45 cycles, W_L0 lasts 5 cycles.
